// File: rtl/ps2_hex_keypad_if.sv
// ps2_hex_keypad_if: PS/2 line inputs and decoded Chip-8 keypad outputs.
interface ps2_hex_keypad_if;
    logic        ps2_clk;
    logic        ps2_data;
    logic [15:0] keys;
    logic        key_down;
    logic [3:0]  key_code;
    logic        frame_err;
    modport master (output ps2_clk, ps2_data, input keys, key_down, key_code, frame_err);
    modport slave  (input ps2_clk, ps2_data, output keys, key_down, key_code, frame_err);
endinterface

// File: rtl/ps2_hex_keypad.sv
// ps2_hex_keypad: PS/2 set-2 receiver mapping 1234/QWER/ASDF/ZXCV onto the Chip-8 hex keypad.
module ps2_hex_keypad #(
    parameter int TIMEOUT_CYCLES = 25000,
    parameter int SYNC_STAGES    = 2
) (
    input logic             clk,
    input logic             rst_n,
    ps2_hex_keypad_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES - 1);
    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;
    logic [SYNC_STAGES-1:0] clk_sync, data_sync;
    logic            clk_prev, clk_s, data_s, fall;
    logic [3:0]      bit_cnt;
    logic [9:0]      shreg;
    logic [TW-1:0]   to_cnt;
    logic [10:0]     frame;
    logic            done, frame_ok, byte_valid, timeout;
    logic [7:0]      rx_byte;
    state_t          state, state_n;
    logic            mapped, make, brk;
    logic [3:0]      idx;
    assign clk_s      = clk_sync[SYNC_STAGES-1];
    assign data_s     = data_sync[SYNC_STAGES-1];
    assign fall       = clk_prev & ~clk_s;
    // the shift register holds the first ten bits; the eleventh is the live sample
    assign frame      = {data_s, shreg};
    assign done       = fall && bit_cnt == 4'd10;
    assign frame_ok   = ~frame[0] & frame[10] & (^frame[9:1]);
    assign byte_valid = done & frame_ok;
    assign rx_byte    = frame[8:1];
    assign timeout    = !fall && bit_cnt != 4'd0 && to_cnt == TO_MAX;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync      <= '1;
            data_sync     <= '1;
            clk_prev      <= 1'b1;
            bit_cnt       <= 4'd0;
            shreg         <= '0;
            to_cnt        <= '0;
            bus.frame_err <= 1'b0;
        end else begin
            clk_sync      <= {clk_sync[SYNC_STAGES-2:0], bus.ps2_clk};
            data_sync     <= {data_sync[SYNC_STAGES-2:0], bus.ps2_data};
            clk_prev      <= clk_s;
            bus.frame_err <= (done & ~frame_ok) | timeout;
            if (fall) begin
                shreg   <= {data_s, shreg[9:1]};
                bit_cnt <= done ? 4'd0 : bit_cnt + 4'd1;
                to_cnt  <= '0;
            end else if (timeout) begin
                bit_cnt <= 4'd0;
                to_cnt  <= '0;
            end else begin
                to_cnt  <= (bit_cnt != 4'd0) ? to_cnt + 1'b1 : '0;
            end
        end
    end
    always_comb begin
        mapped = 1'b1;
        idx    = 4'h0;
        case (rx_byte)
            8'h16: idx = 4'h1;
            8'h1E: idx = 4'h2;
            8'h26: idx = 4'h3;
            8'h25: idx = 4'hC;
            8'h15: idx = 4'h4;
            8'h1D: idx = 4'h5;
            8'h24: idx = 4'h6;
            8'h2D: idx = 4'hD;
            8'h1C: idx = 4'h7;
            8'h1B: idx = 4'h8;
            8'h23: idx = 4'h9;
            8'h2B: idx = 4'hE;
            8'h1A: idx = 4'hA;
            8'h22: idx = 4'h0;
            8'h21: idx = 4'hB;
            8'h2A: idx = 4'hF;
            default: mapped = 1'b0;
        endcase
    end
    always_comb begin
        state_n = state;
        make    = 1'b0;
        brk     = 1'b0;
        if (byte_valid) begin
            state_n = state == IDLE ? (rx_byte == 8'hF0 ? BRK : rx_byte == 8'hE0 ? EXT : IDLE)
                    : state == EXT  ? (rx_byte == 8'hF0 ? EXT_BRK : IDLE)
                    : IDLE;
            make    = state == IDLE && rx_byte != 8'hF0 && rx_byte != 8'hE0 && mapped;
            brk     = state == BRK && mapped;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            bus.keys     <= '0;
            bus.key_down <= 1'b0;
            bus.key_code <= 4'h0;
        end else begin
            state        <= state_n;
            bus.key_down <= make & ~bus.keys[idx];
            if (make) begin
                bus.keys[idx] <= 1'b1;
                if (!bus.keys[idx]) bus.key_code <= idx;
            end
            if (brk) bus.keys[idx] <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ps2_hex_keypad.sv
// tb_ps2_hex_keypad: table of PS/2 frames with key_down scoreboard, plus timeout and reset sequences.
module tb_ps2_hex_keypad;
    localparam int TO   = 300;
    localparam int HALF = 10;
    typedef struct {
        logic [7:0]  code;
        logic [10:0] corrupt;
        logic [15:0] keys;
        logic        pulse;
        logic [3:0]  kc;
        logic        err;
    } vec_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    ps2_hex_keypad_if bus ();
    ps2_hex_keypad #(.TIMEOUT_CYCLES(TO), .SYNC_STAGES(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    int vectors = 0;
    int miscompares = 0;
    int err_seen = 0;
    int err_exp = 0;
    int got_rd = 0;
    logic [3:0] got_q[$];
    logic [3:0] exp_q[$];
    vec_t tbl[$];
    always @(negedge clk) begin
        if (rst_n && bus.key_down) got_q.push_back(bus.key_code);
        if (rst_n && bus.frame_err) err_seen++;
    end
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask
    function automatic logic [10:0] mkframe(input logic [7:0] b);
        return {1'b1, ~^b, b, 1'b0};
    endfunction
    task automatic send_bits(input logic [10:0] f, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            @(negedge clk) bus.ps2_data = f[i];
            repeat (HALF) @(negedge clk);
            bus.ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            bus.ps2_clk = 1'b1;
        end
        repeat (HALF) @(negedge clk);
    endtask
    task automatic check_pulses(input string name);
        check({name, "_pulse_count"}, got_q.size() - got_rd, exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > got_rd) begin
            check({name, "_key_code"}, got_q[got_rd], exp_q.pop_front());
            got_rd++;
        end
        exp_q.delete();
        got_rd = got_q.size();
    endtask
    task automatic send(input string name, input logic [7:0] b, input logic [15:0] k, input logic p, input logic [3:0] kc);
        if (p) exp_q.push_back(kc);
        send_bits(mkframe(b), 0, 10);
        check({name, "_keys"}, bus.keys, k);
        check_pulses(name);
    endtask
    initial begin
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        tbl.push_back(vec_t'{8'h1D, 11'h000, 16'h0020, 1'b1, 4'h5, 1'b0});
        tbl.push_back(vec_t'{8'hF0, 11'h000, 16'h0020, 1'b0, 4'h0, 1'b0});
        tbl.push_back(vec_t'{8'h1D, 11'h000, 16'h0000, 1'b0, 4'h0, 1'b0});
        tbl.push_back(vec_t'{8'h16, 11'h000, 16'h0002, 1'b1, 4'h1, 1'b0});
        tbl.push_back(vec_t'{8'h2A, 11'h000, 16'h8002, 1'b1, 4'hF, 1'b0});
        tbl.push_back(vec_t'{8'h2A, 11'h000, 16'h8002, 1'b0, 4'h0, 1'b0});
        tbl.push_back(vec_t'{8'hF0, 11'h000, 16'h8002, 1'b0, 4'h0, 1'b0});
        tbl.push_back(vec_t'{8'h16, 11'h000, 16'h8000, 1'b0, 4'h0, 1'b0});
        tbl.push_back(vec_t'{8'hF0, 11'h000, 16'h8000, 1'b0, 4'h0, 1'b0});
        tbl.push_back(vec_t'{8'h2A, 11'h000, 16'h0000, 1'b0, 4'h0, 1'b0});
        tbl.push_back(vec_t'{8'hE0, 11'h000, 16'h0000, 1'b0, 4'h0, 1'b0});
        tbl.push_back(vec_t'{8'h75, 11'h000, 16'h0000, 1'b0, 4'h0, 1'b0});
        tbl.push_back(vec_t'{8'hE0, 11'h000, 16'h0000, 1'b0, 4'h0, 1'b0});
        tbl.push_back(vec_t'{8'hF0, 11'h000, 16'h0000, 1'b0, 4'h0, 1'b0});
        tbl.push_back(vec_t'{8'h75, 11'h000, 16'h0000, 1'b0, 4'h0, 1'b0});
        tbl.push_back(vec_t'{8'hE0, 11'h000, 16'h0000, 1'b0, 4'h0, 1'b0});
        tbl.push_back(vec_t'{8'h22, 11'h000, 16'h0000, 1'b0, 4'h0, 1'b0});
        tbl.push_back(vec_t'{8'h75, 11'h000, 16'h0000, 1'b0, 4'h0, 1'b0});
        tbl.push_back(vec_t'{8'h22, 11'h000, 16'h0001, 1'b1, 4'h0, 1'b0});
        tbl.push_back(vec_t'{8'hF0, 11'h000, 16'h0001, 1'b0, 4'h0, 1'b0});
        tbl.push_back(vec_t'{8'h22, 11'h000, 16'h0000, 1'b0, 4'h0, 1'b0});
        tbl.push_back(vec_t'{8'h1C, 11'h200, 16'h0000, 1'b0, 4'h0, 1'b1});
        tbl.push_back(vec_t'{8'h1C, 11'h000, 16'h0080, 1'b1, 4'h7, 1'b0});
        tbl.push_back(vec_t'{8'h15, 11'h001, 16'h0080, 1'b0, 4'h0, 1'b1});
        tbl.push_back(vec_t'{8'h15, 11'h400, 16'h0080, 1'b0, 4'h0, 1'b1});
        tbl.push_back(vec_t'{8'h15, 11'h000, 16'h0090, 1'b1, 4'h4, 1'b0});
        tbl.push_back(vec_t'{8'h2B, 11'h000, 16'h4090, 1'b1, 4'hE, 1'b0});
        tbl.push_back(vec_t'{8'hF0, 11'h000, 16'h4090, 1'b0, 4'h0, 1'b0});
        tbl.push_back(vec_t'{8'h15, 11'h000, 16'h4080, 1'b0, 4'h0, 1'b0});
        tbl.push_back(vec_t'{8'hF0, 11'h000, 16'h4080, 1'b0, 4'h0, 1'b0});
        tbl.push_back(vec_t'{8'h1C, 11'h000, 16'h4000, 1'b0, 4'h0, 1'b0});
        tbl.push_back(vec_t'{8'hF0, 11'h000, 16'h4000, 1'b0, 4'h0, 1'b0});
        tbl.push_back(vec_t'{8'h2B, 11'h000, 16'h0000, 1'b0, 4'h0, 1'b0});
        repeat (4) @(negedge clk);
        check("reset_keys", bus.keys, 16'h0000);
        check("reset_key_down", bus.key_down, 1'b0);
        check("reset_key_code", bus.key_code, 4'h0);
        check("reset_frame_err", bus.frame_err, 1'b0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        foreach (tbl[i]) begin
            if (tbl[i].pulse) exp_q.push_back(tbl[i].kc);
            if (tbl[i].err) err_exp++;
            send_bits(mkframe(tbl[i].code) ^ tbl[i].corrupt, 0, 10);
            check($sformatf("vec%0d_keys", i), bus.keys, tbl[i].keys);
            check($sformatf("vec%0d_frame_err", i), err_seen, err_exp);
            check_pulses($sformatf("vec%0d", i));
        end
        send_bits(mkframe(8'h1B), 0, 4);
        repeat (TO + 20) @(negedge clk);
        err_exp++;
        check("timeout_frame_err", err_seen, err_exp);
        check("timeout_keys", bus.keys, 16'h0000);
        send("after_timeout", 8'h1B, 16'h0100, 1'b1, 4'h8);
        check("after_timeout_err", err_seen, err_exp);
        send("brk_pre", 8'hF0, 16'h0100, 1'b0, 4'h0);
        send("brk_1b", 8'h1B, 16'h0000, 1'b0, 4'h0);
        send("hold_1", 8'h16, 16'h0002, 1'b1, 4'h1);
        send("hold_2", 8'h1E, 16'h0006, 1'b1, 4'h2);
        send_bits(mkframe(8'hF0), 0, 10);
        send_bits(mkframe(8'h26), 0, 4);
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk);
        check("midrst_keys", bus.keys, 16'h0000);
        check("midrst_key_code", bus.key_code, 4'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        send_bits(mkframe(8'h26), 5, 10);
        repeat (TO + 20) @(negedge clk);
        err_exp++;
        check("trailing_frame_err", err_seen, err_exp);
        check("trailing_keys", bus.keys, 16'h0000);
        send("post_rst_f0", 8'hF0, 16'h0000, 1'b0, 4'h0);
        send("post_rst_16", 8'h16, 16'h0000, 1'b0, 4'h0);
        check("post_rst_key_code", bus.key_code, 4'h0);
        send("post_rst_make", 8'h1E, 16'h0004, 1'b1, 4'h2);
        check("final_err", err_seen, err_exp);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
